// File: rtl/tl_mon_pkg.sv
// Shared definitions for the TileLink-UL D-channel response monitor.
// Holds A/D opcode encodings, the error-code enum, the burst FSM state type
// and the beats-per-response helper.
package tl_mon_pkg;

    // A-channel opcodes that the monitor records.
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;

    // D-channel opcodes.
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_A_DUP    = 3'd1,
        ERR_D_NOREQ  = 3'd2,
        ERR_D_OPCODE = 3'd3,
        ERR_D_SIZE   = 3'd4,
        ERR_D_BURST  = 3'd5,
        ERR_D_STABLE = 3'd6
    } err_code_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

    // Data beats for a response of 2^size bytes on a 2^beat_log2-byte bus.
    function automatic int unsigned beats_of(input int unsigned size,
                                             input int unsigned beat_log2);
        if (size <= beat_log2) begin
            return 1;
        end
        return 32'd1 << (size - beat_log2);
    endfunction

endpackage

// File: rtl/tl_source_table.sv
// Per-source in-flight table: pending bit, expected D opcode and size.
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   set_valid/idx/op/size   record a request (set wins over a same-index clear)
//   clr_valid/idx           retire a source
//   a_idx -> a_pending_c    combinational pending lookup for the A side
//   d_idx -> d_*_c          combinational entry lookup for the D side
//   count                   registered number of pending sources
module tl_source_table
    import tl_mon_pkg::*;
#(
    parameter int unsigned SOURCE_W = 4,
    parameter int unsigned SIZE_W   = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                set_valid,
    input  logic [SOURCE_W-1:0] set_idx,
    input  logic                set_op,
    input  logic [SIZE_W-1:0]   set_size,
    input  logic                clr_valid,
    input  logic [SOURCE_W-1:0] clr_idx,
    input  logic [SOURCE_W-1:0] a_idx,
    output logic                a_pending_c,
    input  logic [SOURCE_W-1:0] d_idx,
    output logic                d_pending_c,
    output logic                d_op_c,
    output logic [SIZE_W-1:0]   d_size_c,
    output logic [SOURCE_W:0]   count
);
    localparam int unsigned NUM_SRC = 1 << SOURCE_W;
    localparam int unsigned CNT_W   = SOURCE_W + 1;

    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] op_q, op_d;
    logic [SIZE_W-1:0]  size_q [NUM_SRC];
    logic [SIZE_W-1:0]  size_d [NUM_SRC];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               inc, dec;

    // A set on an already-pending entry only counts if that entry is retiring now.
    assign inc = set_valid && !(pend_q[set_idx] && !(clr_valid && (clr_idx == set_idx)));
    assign dec = clr_valid && pend_q[clr_idx];

    // Clear first so a same-index set overrides it.
    always_comb begin
        pend_d = pend_q;
        op_d   = op_q;
        size_d = size_q;
        if (clr_valid) begin
            pend_d[clr_idx] = 1'b0;
        end
        if (set_valid) begin
            pend_d[set_idx] = 1'b1;
            op_d[set_idx]   = set_op;
            size_d[set_idx] = set_size;
        end
        cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                size_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            op_q   <= op_d;
            size_q <= size_d;
            cnt_q  <= cnt_d;
        end
    end

    assign a_pending_c = pend_q[a_idx];
    assign d_pending_c = pend_q[d_idx];
    assign d_op_c      = op_q[d_idx];
    assign d_size_c    = size_q[d_idx];
    assign count       = cnt_q;

endmodule

// File: rtl/tl_d_response_monitor.sv
// Passive TileLink-UL D-channel checker. Records A-channel requests and checks
// each D response for source, opcode pairing, size, burst consistency and
// hold stability. Errors are sticky; err_code keeps the first one since reset.
// Ports:
//   clock, reset                       clock, synchronous active-high reset
//   a_valid/a_ready/a_opcode/a_source/a_size   observed A channel
//   d_valid/d_ready/d_opcode/d_source/d_size   observed D channel
//   error         sticky error flag
//   err_code      first error code since reset
//   inflight_cnt  number of outstanding sources
`ifndef SYNTHESIS
`ifndef STOP_COND
`define STOP_COND 1'b0
`endif
`ifndef PRINTF_COND
`define PRINTF_COND 1'b1
`endif
`endif

module tl_d_response_monitor
    import tl_mon_pkg::*;
#(
    parameter int unsigned SOURCE_W  = 4,
    parameter int unsigned SIZE_W    = 3,
    parameter int unsigned BEAT_LOG2 = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    input  logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic                d_valid,
    input  logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [SOURCE_W-1:0] d_source,
    input  logic [SIZE_W-1:0]   d_size,
    output logic                error,
    output logic [2:0]          err_code,
    output logic [SOURCE_W:0]   inflight_cnt
);
    localparam int unsigned MAX_BEATS = beats_of((1 << SIZE_W) - 1, BEAT_LOG2);
    localparam int unsigned BCNT_W    = $clog2(MAX_BEATS + 1);

    logic                a_fire, a_rec, d_fire, d_multi;
    logic                a_pend_c, d_pend_c, d_exp_op_c;
    logic [SIZE_W-1:0]   d_rec_size_c;
    logic [SOURCE_W-1:0] d_idx;
    int unsigned         d_beats;

    burst_state_e        state_q, state_d;
    logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [SOURCE_W-1:0] lat_src_q, lat_src_d;
    logic [2:0]          lat_op_q, lat_op_d;
    logic [SIZE_W-1:0]   lat_size_q, lat_size_d;

    logic                stall_q, stall_d;
    logic [2:0]          hold_op_q, hold_op_d;
    logic [SOURCE_W-1:0] hold_src_q, hold_src_d;
    logic [SIZE_W-1:0]   hold_size_q, hold_size_d;

    logic                error_q, error_d;
    err_code_e           err_code_q, err_code_d, err_first;

    logic                retire_v;
    logic [SOURCE_W-1:0] retire_src;
    logic                e_dup, e_noreq, e_op, e_size, e_burst, e_stable, err_any;

    assign a_fire  = a_valid && a_ready;
    assign d_fire  = d_valid && d_ready;
    // Only PutFull, PutPartial and Get are tracked; other opcodes are ignored.
    assign a_rec   = a_fire && ((a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL)
                                || (a_opcode == A_GET));
    assign d_beats = beats_of(32'(d_size), BEAT_LOG2);
    assign d_multi = (d_opcode == D_ACCESS_ACK_DATA) && (d_beats > 1);
    // During a burst the table entry of interest is the latched source.
    assign d_idx   = (state_q == ST_BURST) ? lat_src_q : d_source;

    tl_source_table #(
        .SOURCE_W (SOURCE_W),
        .SIZE_W   (SIZE_W)
    ) u_table (
        .clock       (clock),
        .reset       (reset),
        .set_valid   (a_rec),
        .set_idx     (a_source),
        .set_op      (a_opcode == A_GET),
        .set_size    (a_size),
        .clr_valid   (retire_v),
        .clr_idx     (retire_src),
        .a_idx       (a_source),
        .a_pending_c (a_pend_c),
        .d_idx       (d_idx),
        .d_pending_c (d_pend_c),
        .d_op_c      (d_exp_op_c),
        .d_size_c    (d_rec_size_c),
        .count       (inflight_cnt)
    );

    // Burst FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (d_fire && d_multi) state_d = ST_BURST;
            ST_BURST: if (d_fire && (beat_cnt_q == BCNT_W'(1))) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Burst FSM outputs: beat bookkeeping, retirement and D-side checks.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        lat_src_d  = lat_src_q;
        lat_op_d   = lat_op_q;
        lat_size_d = lat_size_q;
        retire_v   = 1'b0;
        retire_src = d_idx;
        e_noreq    = 1'b0;
        e_op       = 1'b0;
        e_size     = 1'b0;
        e_burst    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_fire) begin
                    if (!d_pend_c) begin
                        e_noreq = 1'b1;
                    end else begin
                        e_op   = d_opcode != {2'b00, d_exp_op_c};
                        e_size = d_size != d_rec_size_c;
                    end
                    if (d_multi) begin
                        beat_cnt_d = BCNT_W'(d_beats - 1);
                        lat_src_d  = d_source;
                        lat_op_d   = d_opcode;
                        lat_size_d = d_size;
                    end else begin
                        retire_v = d_pend_c;
                    end
                end
            end
            ST_BURST: begin
                if (d_fire) begin
                    e_burst    = (d_source != lat_src_q) || (d_opcode != lat_op_q)
                                 || (d_size != lat_size_q);
                    beat_cnt_d = beat_cnt_q - BCNT_W'(1);
                    if (beat_cnt_q == BCNT_W'(1)) begin
                        retire_v = d_pend_c;
                    end
                end
            end
            default: ;
        endcase
    end

    // A-side duplicate, hold stability, priority and sticky error update.
    always_comb begin
        e_dup       = a_rec && a_pend_c && !(retire_v && (retire_src == a_source));
        e_stable    = stall_q && (!d_valid || (d_opcode != hold_op_q)
                                  || (d_source != hold_src_q) || (d_size != hold_size_q));
        stall_d     = d_valid && !d_ready;
        hold_op_d   = d_opcode;
        hold_src_d  = d_source;
        hold_size_d = d_size;

        // Later assignments win, so the lowest code ends up latched.
        err_first = ERR_NONE;
        if (e_stable) err_first = ERR_D_STABLE;
        if (e_burst)  err_first = ERR_D_BURST;
        if (e_size)   err_first = ERR_D_SIZE;
        if (e_op)     err_first = ERR_D_OPCODE;
        if (e_noreq)  err_first = ERR_D_NOREQ;
        if (e_dup)    err_first = ERR_A_DUP;
        err_any = e_dup || e_noreq || e_op || e_size || e_burst || e_stable;

        error_d    = error_q || err_any;
        err_code_d = err_code_q;
        if (!error_q && err_any) begin
            err_code_d = err_first;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            beat_cnt_q  <= '0;
            lat_src_q   <= '0;
            lat_op_q    <= '0;
            lat_size_q  <= '0;
            stall_q     <= 1'b0;
            hold_op_q   <= '0;
            hold_src_q  <= '0;
            hold_size_q <= '0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            lat_src_q   <= lat_src_d;
            lat_op_q    <= lat_op_d;
            lat_size_q  <= lat_size_d;
            stall_q     <= stall_d;
            hold_op_q   <= hold_op_d;
            hold_src_q  <= hold_src_d;
            hold_size_q <= hold_size_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign error    = error_q;
    assign err_code = err_code_q;

`ifndef SYNTHESIS
    // Simulation-only reporting of each violation event.
    always @(posedge clock) begin
        if (!reset && err_any) begin
            if (`PRINTF_COND) begin
                $display("tl_d_response_monitor: protocol violation code %0d at %0t",
                         err_first, $time);
            end
            if (`STOP_COND) begin
                $fatal(1, "tl_d_response_monitor: stopping on violation code %0d", err_first);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tl_d_response_monitor.sv
// Scenario bench for tl_d_response_monitor: each driven cycle pushes its
// expected post-edge outputs to a queue, popped and compared after the edge.
module tb_tl_d_response_monitor;
    import tl_mon_pkg::*;

    localparam int unsigned SOURCE_W  = 4;
    localparam int unsigned SIZE_W    = 3;
    localparam int unsigned BEAT_LOG2 = 2;

    logic                clock;
    logic                reset;
    logic                a_valid, a_ready;
    logic [2:0]          a_opcode;
    logic [SOURCE_W-1:0] a_source;
    logic [SIZE_W-1:0]   a_size;
    logic                d_valid, d_ready;
    logic [2:0]          d_opcode;
    logic [SOURCE_W-1:0] d_source;
    logic [SIZE_W-1:0]   d_size;
    logic                error;
    logic [2:0]          err_code;
    logic [SOURCE_W:0]   inflight_cnt;

    typedef struct {
        string       tag;
        logic        err;
        logic [2:0]  code;
        int unsigned cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    tl_d_response_monitor #(
        .SOURCE_W  (SOURCE_W),
        .SIZE_W    (SIZE_W),
        .BEAT_LOG2 (BEAT_LOG2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_opcode     (a_opcode),
        .a_source     (a_source),
        .a_size       (a_size),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .d_opcode     (d_opcode),
        .d_source     (d_source),
        .d_size       (d_size),
        .error        (error),
        .err_code     (err_code),
        .inflight_cnt (inflight_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        reset    = 1'b0;
        a_valid  = 1'b0;
        a_ready  = 1'b1;
        a_opcode = 3'd0;
        a_source = '0;
        a_size   = '0;
        d_valid  = 1'b0;
        d_ready  = 1'b1;
        d_opcode = 3'd0;
        d_source = '0;
        d_size   = '0;
    endtask

    task automatic set_a(input logic [2:0] op, input int unsigned src, input int unsigned sz);
        a_valid  = 1'b1;
        a_ready  = 1'b1;
        a_opcode = op;
        a_source = SOURCE_W'(src);
        a_size   = SIZE_W'(sz);
    endtask

    task automatic set_d(input logic rdy, input logic [2:0] op, input int unsigned src,
                         input int unsigned sz);
        d_valid  = 1'b1;
        d_ready  = rdy;
        d_opcode = op;
        d_source = SOURCE_W'(src);
        d_size   = SIZE_W'(sz);
    endtask

    // Push the expectation for this cycle, clock it, then compare and go idle.
    task automatic tick(input string tag, input logic e_err, input logic [2:0] e_code,
                        input int unsigned e_cnt);
        exp_t e;
        e.tag  = tag;
        e.err  = e_err;
        e.code = e_code;
        e.cnt  = e_cnt;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".error"}, 32'(error), 32'(e.err));
        check({e.tag, ".code"}, 32'(err_code), 32'(e.code));
        check({e.tag, ".cnt"}, 32'(inflight_cnt), e.cnt);
        drive_idle();
    endtask

    task automatic do_reset(input string tag);
        drive_idle();
        reset = 1'b1;
        tick(tag, 1'b0, 3'd0, 0);
    endtask

    initial begin
        drive_idle();
        do_reset("reset0");

        // Single-beat Get / AccessAckData.
        set_a(A_GET, 3, 2);                  tick("t1_get", 1'b0, 3'd0, 1);
                                             tick("t1_gap", 1'b0, 3'd0, 1);
        set_d(1'b1, D_ACCESS_ACK_DATA, 3, 2); tick("t1_ack", 1'b0, 3'd0, 0);

        // Four-beat burst with gaps.
        set_a(A_GET, 5, 4);                  tick("t2_get", 1'b0, 3'd0, 1);
        for (int b = 0; b < 4; b++) begin
            set_d(1'b1, D_ACCESS_ACK_DATA, 5, 4);
            tick($sformatf("t2_beat%0d", b), 1'b0, 3'd0, (b == 3) ? 0 : 1);
            if (b != 3) tick($sformatf("t2_gap%0d", b), 1'b0, 3'd0, 1);
        end
        check("t2_fsm_idle", 32'(dut.state_q), 32'(ST_IDLE));
        set_a(A_GET, 3, 2);                  tick("t2_get2", 1'b0, 3'd0, 1);
        set_d(1'b1, D_ACCESS_ACK_DATA, 3, 2); tick("t2_ack2", 1'b0, 3'd0, 0);

        // Burst with a source change on beat 3.
        do_reset("reset3");
        set_a(A_GET, 5, 4);                  tick("t3_get", 1'b0, 3'd0, 1);
        set_d(1'b1, D_ACCESS_ACK_DATA, 5, 4); tick("t3_b1", 1'b0, 3'd0, 1);
        set_d(1'b1, D_ACCESS_ACK_DATA, 5, 4); tick("t3_b2", 1'b0, 3'd0, 1);
        set_d(1'b1, D_ACCESS_ACK_DATA, 6, 4); tick("t3_b3", 1'b1, 3'd5, 1);
        set_d(1'b1, D_ACCESS_ACK_DATA, 5, 4); tick("t3_b4", 1'b1, 3'd5, 0);

        // Duplicate Put on the same source.
        do_reset("reset4");
        set_a(A_PUT_FULL, 2, 2);             tick("t4_put1", 1'b0, 3'd0, 1);
        set_a(A_PUT_PARTIAL, 2, 2);          tick("t4_put2", 1'b1, 3'd1, 1);
                                             tick("t4_gap", 1'b1, 3'd1, 1);

        // Response with nothing pending.
        do_reset("reset5");
        set_d(1'b1, D_ACCESS_ACK, 7, 0);     tick("t5_noreq", 1'b1, 3'd2, 0);

        // Get answered with AccessAck; later errors leave the code unchanged.
        do_reset("reset6");
        set_a(A_GET, 1, 2);                  tick("t6_get", 1'b0, 3'd0, 1);
        set_d(1'b1, D_ACCESS_ACK, 1, 2);     tick("t6_ack", 1'b1, 3'd3, 0);
        set_d(1'b1, D_ACCESS_ACK, 7, 0);     tick("t6_sticky", 1'b1, 3'd3, 0);

        // Stall then size change.
        do_reset("reset7");
        set_d(1'b0, D_ACCESS_ACK, 0, 0);     tick("t7_stall", 1'b0, 3'd0, 0);
        set_d(1'b0, D_ACCESS_ACK, 0, 1);     tick("t7_change", 1'b1, 3'd6, 0);

        // Same-cycle A fire and D retire on source 4; new fields take effect.
        do_reset("reset8");
        set_a(A_PUT_FULL, 4, 2);             tick("t8_put", 1'b0, 3'd0, 1);
        set_a(A_GET, 4, 3);
        set_d(1'b1, D_ACCESS_ACK, 4, 2);     tick("t8_both", 1'b0, 3'd0, 1);
        set_d(1'b1, D_ACCESS_ACK_DATA, 4, 3); tick("t8_b1", 1'b0, 3'd0, 1);
        set_d(1'b1, D_ACCESS_ACK_DATA, 4, 3); tick("t8_b2", 1'b0, 3'd0, 0);

        // Illegal A opcode is not recorded.
        do_reset("reset9");
        set_a(3'd2, 9, 0);                   tick("t9_illegal", 1'b0, 3'd0, 0);
        set_d(1'b1, D_ACCESS_ACK, 9, 0);     tick("t9_resp", 1'b1, 3'd2, 0);

        // Duplicate and no-request together: lowest code wins.
        do_reset("reset10");
        set_a(A_PUT_FULL, 8, 1);             tick("t10_put", 1'b0, 3'd0, 1);
        set_a(A_PUT_FULL, 8, 1);
        set_d(1'b1, D_ACCESS_ACK, 10, 0);    tick("t10_prio", 1'b1, 3'd1, 1);

        // Reset mid-burst discards the burst and the table.
        do_reset("reset11");
        set_a(A_GET, 5, 4);                  tick("t11_get", 1'b0, 3'd0, 1);
        set_d(1'b1, D_ACCESS_ACK_DATA, 5, 4); tick("t11_b1", 1'b0, 3'd0, 1);
        do_reset("t11_rst");
        check("t11_fsm_idle", 32'(dut.state_q), 32'(ST_IDLE));
        set_d(1'b1, D_ACCESS_ACK_DATA, 5, 2); tick("t11_after", 1'b1, 3'd2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
